// File: rtl/alu_mux.sv
// ALU source-B operand selector with a clocked debug observation block.
// Optional selection statistics counters are built when ALUMUX_STATS_EN is defined.
module alu_mux #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     RegOperand,
    input  logic [WIDTH-1:0]     ImmExt,
    input  logic                 ALUSrc,
    output logic [WIDTH-1:0]     SrcB,
    output logic [WIDTH-1:0]     SrcBQ,
    output logic [CNT_WIDTH-1:0] RegSelCount,
    output logic [CNT_WIDTH-1:0] ImmSelCount
);

    logic [WIDTH-1:0] srcBQ_r;

    // Operand select; an unknown select propagates as unknown rather than defaulting to a source.
    always_comb begin
        SrcB = {WIDTH{1'bx}};
        case (ALUSrc)
            1'b0:    SrcB = RegOperand;
            1'b1:    SrcB = ImmExt;
            default: SrcB = {WIDTH{1'bx}};
        endcase
    end

    // Debug capture of last-cycle SrcB.
    always_ff @(posedge clk) begin
        if (reset) begin
            srcBQ_r <= {WIDTH{1'b0}};
        end else begin
            srcBQ_r <= SrcB;
        end
    end

    assign SrcBQ = srcBQ_r;

`ifdef ALUMUX_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] regSelCount_r;
    logic [CNT_WIDTH-1:0] immSelCount_r;

    // Saturating selection counters; an unknown select advances neither.
    always_ff @(posedge clk) begin
        if (reset) begin
            regSelCount_r <= {CNT_WIDTH{1'b0}};
            immSelCount_r <= {CNT_WIDTH{1'b0}};
        end else begin
            case (ALUSrc)
                1'b0: begin
                    if (regSelCount_r != CNT_MAX) begin
                        regSelCount_r <= regSelCount_r + CNT_ONE;
                    end else begin
                        regSelCount_r <= regSelCount_r;
                    end
                    immSelCount_r <= immSelCount_r;
                end
                1'b1: begin
                    if (immSelCount_r != CNT_MAX) begin
                        immSelCount_r <= immSelCount_r + CNT_ONE;
                    end else begin
                        immSelCount_r <= immSelCount_r;
                    end
                    regSelCount_r <= regSelCount_r;
                end
                default: begin
                    regSelCount_r <= regSelCount_r;
                    immSelCount_r <= immSelCount_r;
                end
            endcase
        end
    end

    assign RegSelCount = regSelCount_r;
    assign ImmSelCount = immSelCount_r;
`else
    assign RegSelCount = {CNT_WIDTH{1'b0}};
    assign ImmSelCount = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_alu_mux.sv
// Directed self-checking bench for alu_mux: a default-width instance and a
// 4-bit-counter instance sharing the same stimulus.
module tb_alu_mux;

    logic        clk;
    logic        reset;
    logic [31:0] RegOperand;
    logic [31:0] ImmExt;
    logic        ALUSrc;
    logic [31:0] SrcB;
    logic [31:0] SrcBQ;
    logic [15:0] RegSelCount;
    logic [15:0] ImmSelCount;
    logic [31:0] smallSrcB;
    logic [31:0] smallSrcBQ;
    logic [3:0]  smallRegCount;
    logic [3:0]  smallImmCount;

    int checkCount = 0;
    int errorCount = 0;

`ifdef ALUMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    alu_mux #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .RegOperand(RegOperand), .ImmExt(ImmExt),
        .ALUSrc(ALUSrc), .SrcB(SrcB), .SrcBQ(SrcBQ),
        .RegSelCount(RegSelCount), .ImmSelCount(ImmSelCount)
    );

    alu_mux #(.WIDTH(32), .CNT_WIDTH(4)) dutSmall (
        .clk(clk), .reset(reset), .RegOperand(RegOperand), .ImmExt(ImmExt),
        .ALUSrc(ALUSrc), .SrcB(smallSrcB), .SrcBQ(smallSrcBQ),
        .RegSelCount(smallRegCount), .ImmSelCount(smallImmCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected count: the value in a stats build, zero otherwise.
    function automatic logic [31:0] cnt(input logic [31:0] v);
        return STATS ? v : 32'd0;
    endfunction

    initial begin
        reset      = 1'b1;
        RegOperand = 32'd0;
        ImmExt     = 32'd0;
        ALUSrc     = 1'b0;
        tick(1);
        check("reset_srcbq", SrcBQ, 32'd0);
        check("reset_regcnt", {16'd0, RegSelCount}, 32'd0);
        check("reset_immcnt", {16'd0, ImmSelCount}, 32'd0);
        reset = 1'b0;

        // Combinational select of the register operand, no clock needed.
        RegOperand = 32'h1234BEEF; ImmExt = 32'h4321FEEB; ALUSrc = 1'b0;
        #1;
        check("comb_reg", SrcB, 32'h1234BEEF);
        tick(1);
        check("q_reg", SrcBQ, 32'h1234BEEF);

        RegOperand = 32'h10001000; ImmExt = 32'h20002000; ALUSrc = 1'b1;
        #1;
        check("comb_imm", SrcB, 32'h20002000);
        tick(1);
        check("q_imm", SrcBQ, 32'h20002000);

        // Toggle select with all-ones / all-zeros operands; SrcBQ lags one clock.
        RegOperand = 32'hFFFFFFFF; ImmExt = 32'h00000000; ALUSrc = 1'b0;
        #1;
        check("tog0_comb", SrcB, 32'hFFFFFFFF);
        check("tog0_lag", SrcBQ, 32'h20002000);
        tick(1);
        check("tog0_q", SrcBQ, 32'hFFFFFFFF);
        ALUSrc = 1'b1;
        #1;
        check("tog1_comb", SrcB, 32'h00000000);
        check("tog1_lag", SrcBQ, 32'hFFFFFFFF);
        tick(1);
        check("tog1_q", SrcBQ, 32'h00000000);
        ALUSrc = 1'b0;
        #1;
        check("tog2_comb", SrcB, 32'hFFFFFFFF);
        tick(1);
        check("tog2_q", SrcBQ, 32'hFFFFFFFF);

        // Statistics: fresh reset, 3 register cycles then 5 immediate cycles.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        ALUSrc = 1'b0;
        tick(3);
        check("cnt_reg3", {16'd0, RegSelCount}, cnt(32'd3));
        check("cnt_imm0", {16'd0, ImmSelCount}, 32'd0);
        ALUSrc = 1'b1;
        tick(5);
        check("cnt_reg3b", {16'd0, RegSelCount}, cnt(32'd3));
        check("cnt_imm5", {16'd0, ImmSelCount}, cnt(32'd5));

        // Mid-run reset wins over capture and counting; SrcB unaffected.
        ImmExt = 32'hCAFE0001;
        reset  = 1'b1;
        tick(1);
        check("mid_srcbq", SrcBQ, 32'd0);
        check("mid_regcnt", {16'd0, RegSelCount}, 32'd0);
        check("mid_immcnt", {16'd0, ImmSelCount}, 32'd0);
        check("mid_srcb", SrcB, 32'hCAFE0001);
        reset = 1'b0;

        // Saturation on the 4-bit instance: immediate selected for 20 cycles.
        tick(15);
        check("sat_imm15", {28'd0, smallImmCount}, cnt(32'hF));
        tick(5);
        check("sat_imm20", {28'd0, smallImmCount}, cnt(32'hF));
        check("sat_reg0", {28'd0, smallRegCount}, 32'd0);
        check("wide_imm20", {16'd0, ImmSelCount}, cnt(32'd20));
        check("small_q", smallSrcBQ, 32'hCAFE0001);
        ALUSrc = 1'b0;
        tick(1);
        check("sat_other_reg", {28'd0, smallRegCount}, cnt(32'd1));
        check("sat_other_imm", {28'd0, smallImmCount}, cnt(32'hF));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
